// File: rtl/seg14_pkg.sv
// Shared types and constants for the 14-segment scan controller.
// A character entry carries its code, its interpretation mode and the decimal point.
package seg14_pkg;

  typedef struct packed {
    logic [6:0] data;
    logic       ascii;
    logic       dp;
  } char_t;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam char_t      CHAR_RESET  = '{data: ASCII_SPACE, ascii: 1'b1, dp: 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Counter width that stays legal when a phase lasts a single clock.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_ascii_to_14seg.sv
// Character-to-segment converter: hex nibble or a small ASCII set to 14 segments plus DP.
// Bit order: a,b,c,d,e,f,g1,g2,h,i,j,k,l,m in [13:0], decimal point in [14].
module hex_ascii_to_14seg (
  input  logic [6:0]  data,
  input  logic        ascii,
  input  logic        dp_en,
  output logic [14:0] seg
);

  function automatic logic [13:0] hex_glyph(input logic [3:0] v);
    logic [13:0] g;
    case (v)
      4'h0: g = 14'h003F;
      4'h1: g = 14'h0006;
      4'h2: g = 14'h00DB;
      4'h3: g = 14'h008F;
      4'h4: g = 14'h00E6;
      4'h5: g = 14'h00ED;
      4'h6: g = 14'h00FD;
      4'h7: g = 14'h0007;
      4'h8: g = 14'h00FF;
      4'h9: g = 14'h00EF;
      4'hA: g = 14'h00F7;
      4'hB: g = 14'h128F;
      4'hC: g = 14'h0039;
      4'hD: g = 14'h120F;
      4'hE: g = 14'h00F9;
      default: g = 14'h00F1;
    endcase
    return g;
  endfunction

  logic [13:0] glyph;

  always_comb begin
    glyph = 14'h0000;
    if (!ascii) begin
      glyph = hex_glyph(data[3:0]);
    end else if (data inside {[7'h30:7'h39]}) begin
      glyph = hex_glyph(data[3:0]);
    end else if (data inside {[7'h41:7'h46]}) begin
      // 'A'..'F' share the hex glyphs; low nibble 1..6 maps to 10..15.
      glyph = hex_glyph(data[3:0] + 4'd9);
    end else begin
      case (data)
        7'h2D:   glyph = 14'h00C0;
        7'h48:   glyph = 14'h00F6;
        7'h4C:   glyph = 14'h0038;
        7'h50:   glyph = 14'h00F3;
        default: glyph = 14'h0000;
      endcase
    end
  end

  assign seg = {dp_en, glyph};

endmodule

// File: rtl/seg14_scan_ctrl.sv
// Multiplexed 14-segment scan controller with double-buffered character store.
// One shared converter; shadow contents move to the active buffer only at frame boundaries.
module seg14_scan_ctrl
  import seg14_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 2500,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] i_wr_addr,
  input  logic [6:0]                    i_wr_data,
  input  logic                          i_wr_ascii,
  input  logic                          i_wr_dp,
  input  logic                          i_commit,
  output logic                          o_commit_pending,
  output logic                          o_frame_pulse,
  output logic [NUM_DIGITS-1:0]         o_digit_en,
  output logic [14:0]                   o_14_seg
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = cnt_width(BLANK_CYCLES);
  localparam int DW = cnt_width(DWELL_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

  scan_state_t           state_reg, state_next;
  logic [IW-1:0]         index_reg, index_next;
  logic [BW-1:0]         blank_cnt_reg, blank_cnt_next;
  logic [DW-1:0]         dwell_cnt_reg, dwell_cnt_next;
  logic                  pending_reg, pending_next;
  logic                  frame_pulse_reg, frame_pulse_next;
  logic [NUM_DIGITS-1:0] digit_en_reg, digit_en_next;
  logic [14:0]           seg_reg, seg_next;
  logic                  frame_end, commit_apply;

  char_t                 shadow_reg [NUM_DIGITS];
  char_t                 active_reg [NUM_DIGITS];
  char_t                 cur_char;
  logic [14:0]           conv_seg;
  logic [NUM_DIGITS-1:0] digit_onehot;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
    assign digit_onehot[gi] = (index_reg == IW'(gi));
  end

  assign cur_char = active_reg[index_reg];

  hex_ascii_to_14seg u_conv (
    .data  (cur_char.data),
    .ascii (cur_char.ascii),
    .dp_en (cur_char.dp),
    .seg   (conv_seg)
  );

  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    blank_cnt_next = blank_cnt_reg;
    dwell_cnt_next = dwell_cnt_reg;
    frame_end      = 1'b0;
    if (!i_enable) begin
      state_next     = ST_IDLE;
      index_next     = '0;
      blank_cnt_next = '0;
      dwell_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next     = ST_BLANK;
          index_next     = '0;
          blank_cnt_next = '0;
        end
        ST_BLANK: begin
          if (blank_cnt_reg == BLANK_LAST) begin
            state_next     = ST_SHOW;
            blank_cnt_next = '0;
            dwell_cnt_next = '0;
          end else begin
            blank_cnt_next = blank_cnt_reg + 1'b1;
          end
        end
        ST_SHOW: begin
          if (dwell_cnt_reg == DWELL_LAST) begin
            state_next     = ST_BLANK;
            dwell_cnt_next = '0;
            frame_end      = (index_reg == LAST_DIGIT);
            index_next     = frame_end ? '0 : index_reg + 1'b1;
          end else begin
            dwell_cnt_next = dwell_cnt_reg + 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // A commit arriving on the boundary edge itself is honoured there.
    commit_apply     = (frame_end && (pending_reg || i_commit)) ||
                       (state_reg == ST_IDLE && pending_reg);
    pending_next     = commit_apply ? 1'b0 : (pending_reg | i_commit);
    frame_pulse_next = frame_end;

    digit_en_next = digit_en_reg;
    seg_next      = seg_reg;
    if (state_next == ST_SHOW) begin
      if (state_reg != ST_SHOW) begin
        digit_en_next = digit_onehot;
        seg_next      = conv_seg;
      end
    end else begin
      digit_en_next = '0;
      seg_next      = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg       <= ST_IDLE;
      index_reg       <= '0;
      blank_cnt_reg   <= '0;
      dwell_cnt_reg   <= '0;
      pending_reg     <= 1'b0;
      frame_pulse_reg <= 1'b0;
      digit_en_reg    <= '0;
      seg_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      index_reg       <= index_next;
      blank_cnt_reg   <= blank_cnt_next;
      dwell_cnt_reg   <= dwell_cnt_next;
      pending_reg     <= pending_next;
      frame_pulse_reg <= frame_pulse_next;
      digit_en_reg    <= digit_en_next;
      seg_reg         <= seg_next;
    end
  end

  // Copy reads pre-edge shadow, so a write on the copy edge stays in shadow only.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_reg[i] <= CHAR_RESET;
        active_reg[i] <= CHAR_RESET;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (i_wr_en && i_wr_addr == IW'(i)) begin
          shadow_reg[i] <= '{data: i_wr_data, ascii: i_wr_ascii, dp: i_wr_dp};
        end
        if (commit_apply) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
    end
  end

  assign o_commit_pending = pending_reg;
  assign o_frame_pulse    = frame_pulse_reg;
  assign o_digit_en       = digit_en_reg;
  assign o_14_seg         = seg_reg;

endmodule
